// File: rtl/qracc_pkg.sv
// qracc_pkg: shared SRAM request types, responder states and default array timing.
package qracc_pkg;
  localparam int SRAM_ROWS = 128;
  localparam int SRAM_COLS = 32;
  localparam int PCH_CYCLES = 1;
  localparam int WL_CYCLES = 2;
  localparam int SA_CYCLES = 1;
  typedef enum logic [2:0] {IDLE, PRE, WLA, SENSE, RESP, REC} sram_rq_state_t;
  typedef struct packed {
    logic rq_valid;
    logic rq_wr;
    logic [$clog2(SRAM_ROWS)-1:0] addr;
    logic [SRAM_COLS-1:0] wr_data;
  } to_sram_t;
  typedef struct packed {
    logic rq_ready;
    logic rd_valid;
    logic [SRAM_COLS-1:0] rd_data;
  } from_sram_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/sram_rq_responder_wl_decoder.sv
// wl_decoder: row address to one-hot wordline; all zero when disabled or out of range.
module wl_decoder #(
  parameter int numRows = 128,
  parameter int AW = $clog2(numRows)
) (
  input  logic               en,
  input  logic [AW-1:0]      addr,
  output logic [numRows-1:0] wl
);
  always_comb begin
    wl = '0;
    if (en && int'(addr) < numRows) wl[addr] = 1'b1;
  end
endmodule

// File: rtl/sram_rq_responder.sv
// sram_rq_responder: sequences SRAM array controls for single-word requests.
// Define SRAM_RQ_BUF_EN to add a one-entry pending-request buffer.
module sram_rq_responder
  import qracc_pkg::*;
#(
  parameter int numRows = SRAM_ROWS,
  parameter int numCols = SRAM_COLS,
  parameter int pchCycles = PCH_CYCLES,
  parameter int wlCycles = WL_CYCLES,
  parameter int saCycles = SA_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_en_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       busy_o,
  output logic                       PCH,
  output logic [numRows-1:0]         WL,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);
  localparam int AW = $clog2(numRows);
  localparam int CW = $clog2(max3(pchCycles, wlCycles, saCycles) + 1);
  sram_rq_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [AW-1:0] cur_addr, nxt_addr;
  logic cur_wr, nxt_wr;
  logic [numCols-1:0] cur_data, nxt_data;
  logic acc, last, load, pend;
  assign acc = rq_valid_i && rq_ready_o;
  assign last = cnt == '0;
`ifdef SRAM_RQ_BUF_EN
  logic buf_v, buf_wr;
  logic [AW-1:0] buf_addr;
  logic [numCols-1:0] buf_data;
  assign rq_ready_o = !mac_en_i && (state == IDLE || !buf_v);
  assign pend = buf_v || acc;
  assign nxt_addr = buf_v ? buf_addr : addr_i;
  assign nxt_wr = buf_v ? buf_wr : rq_wr_i;
  assign nxt_data = buf_v ? buf_data : wr_data_i;
  // A request that cannot start right away waits here until RESP/REC.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v <= 1'b0;
      buf_wr <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (load && buf_v) begin
      buf_v <= 1'b0;
    end else if (acc && !load) begin
      buf_v <= 1'b1;
      buf_wr <= rq_wr_i;
      buf_addr <= addr_i;
      buf_data <= wr_data_i;
    end
  end
`else
  assign rq_ready_o = state == IDLE && !mac_en_i;
  assign pend = 1'b0;
  assign nxt_addr = addr_i;
  assign nxt_wr = rq_wr_i;
  assign nxt_data = wr_data_i;
`endif
  function automatic logic [CW-1:0] dur(input sram_rq_state_t s);
    return s == PRE ? CW'(pchCycles - 1) : s == WLA ? CW'(wlCycles - 1) :
           s == SENSE ? CW'(saCycles - 1) : '0;
  endfunction
  always_comb begin
    state_n = state;
    load = 1'b0;
    case (state)
      IDLE: if (acc) begin
        state_n = PRE;
        load = 1'b1;
      end
      PRE: if (last) state_n = WLA;
      WLA: if (last) state_n = cur_wr ? REC : SENSE;
      SENSE: if (last) state_n = RESP;
      RESP, REC: begin
        state_n = pend ? PRE : IDLE;
        load = pend;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_addr <= '0;
      cur_wr <= 1'b0;
      cur_data <= '0;
      rd_data_o <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? dur(state_n) : last ? cnt : cnt - 1'b1;
      if (load) begin
        cur_addr <= nxt_addr;
        cur_wr <= nxt_wr;
        cur_data <= nxt_data;
      end
      if (state == SENSE && last) rd_data_o <= SA_OUT;
    end
  end
  wl_decoder #(.numRows(numRows), .AW(AW)) u_wl_decoder (
    .en  (state == WLA || state == SENSE),
    .addr(cur_addr),
    .wl  (WL)
  );
  assign busy_o = state != IDLE;
  assign rd_valid_o = state == RESP;
  assign PCH = state == PRE;
  assign WRITE = state == WLA && cur_wr;
  assign WR_DATA = WRITE ? cur_data : '0;
  assign CSEL = state == WLA ? '1 : '0;
  assign SAEN = state == SENSE;
endmodule

// File: tb/tb_sram_rq_responder.sv
// tb_sram_rq_responder: directed self-checking bench for sram_rq_responder (default 128x32, 1/2/1 timing).
module tb_sram_rq_responder;
`ifdef SRAM_RQ_BUF_EN
  localparam logic BUF = 1'b1;
`else
  localparam logic BUF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, mac_en_i = 1'b0, rq_valid_i = 1'b0, rq_wr_i = 1'b0;
  logic rq_ready_o, rd_valid_o, busy_o, PCH, WRITE, SAEN;
  logic [6:0] addr_i = '0;
  logic [31:0] wr_data_i = '0, rd_data_o, WR_DATA, CSEL, SA_OUT = '0;
  logic [127:0] WL, prev;
  int total = 0, passed = 0, fails = 0;
  int a, ev, bad, pulses;
  logic acc_now;
  always #5 clk = ~clk;
  sram_rq_responder dut (
    .clk(clk), .rst(rst), .mac_en_i(mac_en_i), .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o),
    .rq_wr_i(rq_wr_i), .addr_i(addr_i), .wr_data_i(wr_data_i), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .PCH(PCH), .WL(WL), .WRITE(WRITE), .WR_DATA(WR_DATA),
    .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step;
    step;
    rst = 1'b0;
    chk("rst_ready", rq_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_ctrl", {PCH, WRITE, SAEN, rd_valid_o}, 0);
    chk("rst_wl", WL, 0);
    chk("rst_csel", CSEL, 0);
    chk("rst_rd_data", rd_data_o, 0);
    // write addr 5: PRE c0, WLA c1-c2, REC c3, ready c4
    rq_valid_i = 1; rq_wr_i = 1; addr_i = 5; wr_data_i = 32'hDEADBEEF;
    step;
    rq_valid_i = 0; addr_i = 9; wr_data_i = 0;
    chk("wr_c0_pch", PCH, 1);
    chk("wr_c0_wl", WL, 0);
    chk("wr_c0_busy", busy_o, 1);
    chk("wr_c0_ready", rq_ready_o, BUF);
    step;
    chk("wr_c1_wl", WL, 128'(1) << 5);
    chk("wr_c1_ctrl", {PCH, WRITE, SAEN}, 3'b010);
    chk("wr_c1_data", WR_DATA, 32'hDEADBEEF);
    chk("wr_c1_csel", CSEL, 32'hFFFFFFFF);
    step;
    chk("wr_c2_wl", WL, 128'(1) << 5);
    chk("wr_c2_write", WRITE, 1);
    step;
    chk("wr_c3_rec", {WL != 0, WRITE, PCH, busy_o}, 4'b0001);
    step;
    chk("wr_c4_ready", {rq_ready_o, busy_o}, 2'b10);
    // read addr 5: SENSE c3, RESP c4
    SA_OUT = 32'h12345678; rq_valid_i = 1; rq_wr_i = 0; addr_i = 5;
    step;
    rq_valid_i = 0;
    chk("rd_c0_pch", PCH, 1);
    step;
    chk("rd_c1_wl", WL, 128'(1) << 5);
    chk("rd_c1_nowrite", {WRITE, WR_DATA}, 0);
    step;
    chk("rd_c2_saen", SAEN, 0);
    step;
    chk("rd_c3_saen", {SAEN, rd_valid_o}, 2'b10);
    chk("rd_c3_wl", WL, 128'(1) << 5);
    step;
    chk("rd_c4_valid", {SAEN, rd_valid_o}, 2'b01);
    chk("rd_c4_data", rd_data_o, 32'h12345678);
    SA_OUT = 32'h0;
    step;
    chk("rd_c5_valid", rd_valid_o, 0);
    chk("rd_c5_hold", rd_data_o, 32'h12345678);
    chk("rd_c5_ready", rq_ready_o, 1);
    // mac_en holds off accept; raising it mid-access does not abort
    mac_en_i = 1; rq_valid_i = 1; rq_wr_i = 1; addr_i = 3; wr_data_i = 32'h3C;
    #1;
    chk("mac_ready", rq_ready_o, 0);
    step;
    step;
    chk("mac_noaccept", busy_o, 0);
    mac_en_i = 0;
    #1;
    chk("mac_release_ready", rq_ready_o, 1);
    step;
    mac_en_i = 1;
    chk("mac_accept", {busy_o, PCH}, 2'b11);
    step;
    chk("mac_mid_wl", WL, 128'(1) << 3);
    chk("mac_mid_data", WR_DATA, 32'h3C);
    step;
    step;
    chk("mac_rec_busy", busy_o, 1);
    step;
    chk("mac_done", {busy_o, rq_ready_o}, 0);
    step;
    chk("mac_no_reaccept", {busy_o, PCH}, 0);
    rq_valid_i = 0; mac_en_i = 0;
    // reset during cycle 2 of a read
    SA_OUT = 32'hAAAA5555; rq_valid_i = 1; rq_wr_i = 0; addr_i = 7;
    step;
    rq_valid_i = 0;
    step;
    step;
    rst = 1;
    step;
    rst = 0;
    chk("abort_idle", {busy_o, PCH, WRITE, SAEN, rd_valid_o}, 0);
    chk("abort_wl", WL, 0);
    chk("abort_rd_data", rd_data_o, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step;
      if (rd_valid_o) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    // back-to-back writes to every row with data = addr
    rq_wr_i = 1; a = 0; addr_i = 0; wr_data_i = 0; rq_valid_i = 1; ev = 0; bad = 0; prev = '0;
    for (int k = 0; k < 1000 && !(ev == 128 && !busy_o); k++) begin
      acc_now = rq_valid_i && rq_ready_o;
      step;
      if (acc_now) begin
        a++;
        if (a == 128) rq_valid_i = 0;
        else begin
          addr_i = 7'(a);
          wr_data_i = 32'(a);
        end
      end
      if (WL != 0 && WL != prev) begin
        if (WL != (128'(1) << ev) || WR_DATA != 32'(ev)) bad++;
        ev++;
      end
      prev = WL;
    end
    chk("sweep_accepts", a, 128);
    chk("sweep_events", ev, 128);
    chk("sweep_order", bad, 0);
`ifdef SRAM_RQ_BUF_EN
    // second read issued during SENSE of the first goes straight RESP -> PRE
    SA_OUT = 32'h0BAD_F00D; rq_valid_i = 1; rq_wr_i = 0; addr_i = 1;
    step;
    rq_valid_i = 0;
    step;
    step;
    step;
    chk("buf_sense", SAEN, 1);
    rq_valid_i = 1; addr_i = 2;
    step;
    rq_valid_i = 0;
    SA_OUT = 32'h5555_AAAA;
    chk("buf_resp1", {rd_valid_o, rq_ready_o}, 2'b10);
    chk("buf_rd1", rd_data_o, 32'h0BAD_F00D);
    step;
    chk("buf_no_idle", {busy_o, PCH}, 2'b11);
    step;
    chk("buf_wl2", WL, 128'(1) << 2);
    step;
    step;
    chk("buf_sense2", {SAEN, rd_valid_o}, 2'b10);
    step;
    chk("buf_resp2", rd_valid_o, 1);
    chk("buf_rd2", rd_data_o, 32'h5555_AAAA);
    step;
    chk("buf_idle", busy_o, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
